fibonacci_decode: RTL and testbench

FIBONACCI_DECODE -- requirements
Module: fibonacci_decode

---
 rtl/fibonacci_decode_pkg.sv | 17 +
 rtl/fibonacci_decode_if.sv | 35 +++
 rtl/fibonacci_decode_weight_gen.sv | 44 ++++
 rtl/fibonacci_decode.sv | 119 +++++++++++
 tb/tb_fibonacci_decode.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fibonacci_decode_pkg.sv
// Shared widths, FSM encoding and Fibonacci weight seeds for the fibonacci_decode block.
// The weight sequence is w0=1, w1=2, w(i)=w(i-1)+w(i-2), so w31=3524578.
package fib_pkg;

    localparam int CODE_W_DEF = 32;
    localparam int BIN_W_DEF  = 16;
    localparam int ACC_W_DEF  = 24;

    typedef logic [0:0] state_t;

    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_RUN  = 1'b1;

    localparam int FIB_SEED_A = 1;
    localparam int FIB_SEED_B = 2;

endpackage

// File: rtl/fibonacci_decode_if.sv
// Start/code/result bundle of the Fibonacci decoder; the decoder is the slave side.
interface fibonacci_decode_if #(
    parameter int CODE_W = fib_pkg::CODE_W_DEF,
    parameter int BIN_W  = fib_pkg::BIN_W_DEF
);

    logic              begin_f_b;
    logic [CODE_W-1:0] fibonacci_code;
    logic [BIN_W-1:0]  output_bin;
    logic              convert_done;
    logic              busy;
    logic              overflow;
    logic              adj_err;

    modport master (
        output begin_f_b,
        output fibonacci_code,
        input  output_bin,
        input  convert_done,
        input  busy,
        input  overflow,
        input  adj_err
    );

    modport slave (
        input  begin_f_b,
        input  fibonacci_code,
        output output_bin,
        output convert_done,
        output busy,
        output overflow,
        output adj_err
    );

endinterface

// File: rtl/fibonacci_decode_weight_gen.sv
// Fibonacci weight stepper: fa holds the weight of the bit currently at the shift LSB,
// fb the next weight; seeding loads (1, 2), advancing moves one position up.
module fib_weight_gen
    import fib_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_i,
    input  logic         advance_i,
    output logic [W-1:0] fa_o,
    output logic [W-1:0] fb_o
);

    logic [W-1:0] fa_q, fa_d;
    logic [W-1:0] fb_q, fb_d;

    always_comb begin
        fa_d = fa_q;
        fb_d = fb_q;
        if (seed_i) begin
            fa_d = W'(FIB_SEED_A);
            fb_d = W'(FIB_SEED_B);
        end else if (advance_i) begin
            fa_d = fb_q;
            fb_d = fa_q + fb_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa_q <= '0;
            fb_q <= '0;
        end else begin
            fa_q <= fa_d;
            fb_q <= fb_d;
        end
    end

    assign fa_o = fa_q;
    assign fb_o = fb_q;

endmodule

// File: rtl/fibonacci_decode.sv
// Serial Fibonacci-code to binary decoder: one code bit per cycle, LSB first, stopping as
// soon as the remaining shifted code is zero; results are held until the next completion.
module fibonacci_decode
    import fib_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int BIN_W  = BIN_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fibonacci_decode_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              prev_q, prev_d;
    logic              adj_q, adj_d;
    logic [BIN_W-1:0]  out_bin_q, out_bin_d;
    logic              ovf_q, ovf_d;
    logic              adj_err_q, adj_err_d;
    logic              done_q, done_d;

    logic              seed;
    logic              advance;
    logic [ACC_W-1:0]  fa;
    logic [ACC_W-1:0]  fb;

    fib_weight_gen #(
        .W (ACC_W)
    ) u_weight_gen (
        .clk       (clk),
        .rst       (rst),
        .seed_i    (seed),
        .advance_i (advance),
        .fa_o      (fa),
        .fb_o      (fb)
    );

    // fb only feeds the stepper itself; the datapath consumes fa alone.
    logic unused_fb;
    assign unused_fb = ^fb;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        adj_d     = adj_q;
        out_bin_d = out_bin_q;
        ovf_d     = ovf_q;
        adj_err_d = adj_err_q;
        done_d    = 1'b0;
        seed      = 1'b0;
        advance   = 1'b0;

        if (state_q == S_IDLE) begin
            if (bus.begin_f_b) begin
                shift_d = bus.fibonacci_code;
                acc_d   = '0;
                prev_d  = 1'b0;
                adj_d   = 1'b0;
                seed    = 1'b1;
                state_d = S_RUN;
            end
        end else begin
            if (shift_q != '0) begin
                if (shift_q[0]) begin
                    acc_d = acc_q + fa;
                end
                if (shift_q[0] && prev_q) begin
                    adj_d = 1'b1;
                end
                prev_d  = shift_q[0];
                shift_d = shift_q >> 1;
                advance = 1'b1;
            end else begin
                // Any set bit above BIN_W-1 means the sum did not fit the binary output.
                out_bin_d = acc_q[BIN_W-1:0];
                ovf_d     = |acc_q[ACC_W-1:BIN_W];
                adj_err_d = adj_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            acc_q     <= '0;
            prev_q    <= 1'b0;
            adj_q     <= 1'b0;
            out_bin_q <= '0;
            ovf_q     <= 1'b0;
            adj_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            adj_q     <= adj_d;
            out_bin_q <= out_bin_d;
            ovf_q     <= ovf_d;
            adj_err_q <= adj_err_d;
            done_q    <= done_d;
        end
    end

    assign bus.output_bin   = out_bin_q;
    assign bus.convert_done = done_q;
    assign bus.busy         = (state_q == S_RUN);
    assign bus.overflow     = ovf_q;
    assign bus.adj_err      = adj_err_q;

endmodule

// File: tb/tb_fibonacci_decode.sv
// Directed bench for fibonacci_decode: expected results come from an independent weight-sum
// model, are queued at each start and popped when convert_done appears.
module tb_fibonacci_decode;

    typedef struct {
        logic [31:0] code;
        logic [15:0] bin;
        logic        ovf;
        logic        adj;
        int          lat;
        int          busyCycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fibonacci_decode_if bus ();

    fibonacci_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model(input logic [31:0] code);
        exp_t        e;
        logic [23:0] w[32];
        logic [23:0] sum;
        int          h;
        w[0] = 24'd1;
        w[1] = 24'd2;
        for (int i = 2; i < 32; i++) w[i] = w[i-1] + w[i-2];
        sum = '0;
        h   = -1;
        for (int i = 0; i < 32; i++) begin
            if (code[i]) begin
                sum = sum + w[i];
                h   = i;
            end
        end
        e.code       = code;
        e.bin        = sum[15:0];
        e.ovf        = (sum > 24'd65535);
        e.adj        = |(code & (code >> 1));
        e.lat        = (h < 0) ? 1 : h + 2;
        e.busyCycles = e.lat - 1;
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive a start across one rising edge; returns #1 after that edge.
    task automatic applyStimulus(input logic [31:0] code);
        @(negedge clk);
        bus.begin_f_b      = 1'b1;
        bus.fibonacci_code = code;
        @(posedge clk);
        #1;
        bus.begin_f_b = 1'b0;
        sbQ.push_back(model(code));
    endtask

    // elapsed = edges already consumed since the start edge before this call.
    task automatic checkOutput(input string tag, input int elapsed);
        int   cyc;
        int   busyCnt;
        exp_t e;
        cyc     = elapsed;
        busyCnt = elapsed;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.convert_done === 1'b1) break;
            if (bus.busy === 1'b1) busyCnt++;
            if (cyc >= 45) break;
        end
        checkVal({tag, "_done"}, {31'd0, bus.convert_done}, 32'd1);
        checkVal({tag, "_sbq"}, (sbQ.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (bus.convert_done === 1'b1 && sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal({tag, "_bin"}, {16'd0, bus.output_bin}, {16'd0, e.bin});
            checkVal({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
            checkVal({tag, "_adj"}, {31'd0, bus.adj_err}, {31'd0, e.adj});
            checkVal({tag, "_lat"}, cyc, e.lat);
            checkVal({tag, "_busy"}, busyCnt, e.busyCycles);
            checkVal({tag, "_busyAtDone"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        int doneSeen;
        int busySeen;
        logic [31:0] rcode;

        rst                = 1'b1;
        bus.begin_f_b      = 1'b0;
        bus.fibonacci_code = '0;
        #12;
        checkVal("rst_bin", {16'd0, bus.output_bin}, 32'd0);
        checkVal("rst_done", {31'd0, bus.convert_done}, 32'd0);
        checkVal("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkVal("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        checkVal("rst_adj", {31'd0, bus.adj_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'h0000_0000);
        checkOutput("zero", 0);
        @(posedge clk);
        #1;
        checkVal("zero_pulse", {31'd0, bus.convert_done}, 32'd0);

        applyStimulus(32'h0000_0015);
        checkOutput("c15", 0);
        // Start in the very cycle convert_done is high.
        applyStimulus(32'h0000_0003);
        checkVal("b2b_pulse", {31'd0, bus.convert_done}, 32'd0);
        checkVal("b2b_busy", {31'd0, bus.busy}, 32'd1);
        checkOutput("c03", 0);

        applyStimulus(32'h0080_0000);
        checkOutput("bit23", 0);
        applyStimulus(32'h0040_0000);
        checkOutput("bit22", 0);
        applyStimulus(32'hFFFF_FFFF);
        checkOutput("ones", 0);

        repeat (5) @(posedge clk);
        #1;
        checkVal("hold_bin", {16'd0, bus.output_bin}, 32'd52423);
        checkVal("hold_ovf", {31'd0, bus.overflow}, 32'd1);
        checkVal("hold_adj", {31'd0, bus.adj_err}, 32'd1);
        checkVal("hold_done", {31'd0, bus.convert_done}, 32'd0);

        applyStimulus(32'h0000_0015);
        repeat (2) begin
            @(negedge clk);
            bus.begin_f_b      = 1'b1;
            bus.fibonacci_code = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
        end
        bus.begin_f_b = 1'b0;
        checkOutput("ignore", 2);
        busySeen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1) busySeen++;
        end
        checkVal("noqueue_busy", busySeen, 0);

        applyStimulus(32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sbQ.delete();
        checkVal("abort_bin", {16'd0, bus.output_bin}, 32'd0);
        checkVal("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkVal("abort_ovf", {31'd0, bus.overflow}, 32'd0);
        checkVal("abort_adj", {31'd0, bus.adj_err}, 32'd0);
        checkVal("abort_done", {31'd0, bus.convert_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        busySeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.convert_done === 1'b1) doneSeen++;
            if (bus.busy === 1'b1) busySeen++;
        end
        checkVal("abort_nodone", doneSeen, 0);
        checkVal("abort_idle", busySeen, 0);

        applyStimulus(32'h0040_0000);
        checkOutput("post_rst", 0);

        for (int k = 0; k < 4; k++) begin
            rcode = $urandom;
            rcode = rcode >> $urandom_range(0, 31);
            applyStimulus(rcode);
            checkOutput("rand", 0);
        end

        $display("[TB] directed sequence complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
